magma_cmp_stream: RTL and testbench

Streaming, parametrised unsigned/signed comparator: the pipelined successor to the single-bit combinational `uge` primitive. It accepts operand pairs plus an opcode over a valid/ready handshake and returns a 1-bit result through a two-stage registered pipeline with full backpressure. It also keeps a saturating count of true results and a sticky illegal-opcode flag. It sits between operand producers and control logic in magma-generated datapaths.

---
 rtl/magma_cmp_pkg.sv | 33 +++
 rtl/magma_cmp_core.sv | 37 +++
 rtl/magma_cmp_stream.sv | 97 +++++++++
 tb/tb_magma_cmp_stream.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/magma_cmp_pkg.sv
// rtl/magma_cmp_pkg.sv - shared opcode enum and legality helpers for the streaming comparator
// Signed opcodes are legal only when MAGMA_CMP_SIGNED_EN is defined.
package magma_cmp_pkg;

  localparam int CMP_OP_W = 3;

`ifdef MAGMA_CMP_SIGNED_EN
  localparam bit CMP_SIGNED_EN = 1'b1;
`else
  localparam bit CMP_SIGNED_EN = 1'b0;
`endif

  typedef enum logic [CMP_OP_W-1:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_ULT = 3'd2,
    CMP_ULE = 3'd3,
    CMP_UGT = 3'd4,
    CMP_UGE = 3'd5,
    CMP_SLT = 3'd6,
    CMP_SGE = 3'd7
  } cmp_op_e;

  function automatic logic cmp_is_signed(input logic [CMP_OP_W-1:0] op);
    return (cmp_op_e'(op) == CMP_SLT) || (cmp_op_e'(op) == CMP_SGE);
  endfunction

  // Without the signed build, the two signed opcodes have no hardware behind them.
  function automatic logic cmp_op_illegal(input logic [CMP_OP_W-1:0] op);
    return cmp_is_signed(op) && !CMP_SIGNED_EN;
  endfunction

endpackage

// File: rtl/magma_cmp_core.sv
// rtl/magma_cmp_core.sv - combinational WIDTH-bit compare for all eight opcodes
// Signed compare logic exists only when MAGMA_CMP_SIGNED_EN is defined.
module magma_cmp_core
  import magma_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [CMP_OP_W-1:0] op,
  output logic                res,
  output logic                illegal
);

  always_comb begin
    res     = 1'b0;
    illegal = cmp_op_illegal(op);
    case (cmp_op_e'(op))
      CMP_EQ:  res = (a == b);
      CMP_NE:  res = (a != b);
      CMP_ULT: res = (a <  b);
      CMP_ULE: res = (a <= b);
      CMP_UGT: res = (a >  b);
      CMP_UGE: res = (a >= b);
`ifdef MAGMA_CMP_SIGNED_EN
      // With WIDTH=1 the lone bit is the sign, so 1 reads as -1.
      CMP_SLT: res = ($signed(a) <  $signed(b));
      CMP_SGE: res = ($signed(a) >= $signed(b));
`else
      CMP_SLT: res = 1'b0;
      CMP_SGE: res = 1'b0;
`endif
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/magma_cmp_stream.sv
// rtl/magma_cmp_stream.sv - two-stage valid/ready compare pipeline with hit counter and opcode error flag
// Signed opcodes 6/7 are built only under MAGMA_CMP_SIGNED_EN; otherwise they flag op_err.
module magma_cmp_stream
  import magma_cmp_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic [WIDTH-1:0]       I0,
  input  logic [WIDTH-1:0]       I1,
  input  logic [CMP_OP_W-1:0]    op,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   O,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   count_clr,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic                   op_err
);

  localparam logic [COUNT_WIDTH-1:0] HIT_MAX = '1;

  logic                s1_v;
  logic [WIDTH-1:0]    s1_a;
  logic [WIDTH-1:0]    s1_b;
  logic [CMP_OP_W-1:0] s1_op;
  logic                s2_v;
  logic                s2_o;

  logic s1_rdy, s2_rdy;
  logic accept, advance, hit_xfer;
  logic core_res, core_illegal;

  // No skid buffer: readiness ripples straight back from out_ready.
  assign s2_rdy   = !s2_v || out_ready;
  assign s1_rdy   = !s1_v || s2_rdy;
  assign in_ready = s1_rdy;

  assign accept   = in_valid && s1_rdy;
  assign advance  = s1_v && s2_rdy;
  assign hit_xfer = s2_v && out_ready && s2_o;

  assign out_valid = s2_v;
  assign O         = s2_o;

  magma_cmp_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .res    (core_res),
    .illegal(core_illegal)
  );

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_op <= '0;
      s2_v  <= 1'b0;
      s2_o  <= 1'b0;
    end else begin
      if (s1_rdy) s1_v <= in_valid;
      if (accept) begin
        s1_a  <= I0;
        s1_b  <= I1;
        s1_op <= op;
      end
      if (s2_rdy) s2_v <= s1_v;
      if (advance) s2_o <= core_res && !core_illegal;
    end
  end

  // Clear beats a same-cycle hit; a same-cycle illegal accept beats clear.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      hit_count <= '0;
      op_err    <= 1'b0;
    end else begin
      if (count_clr)
        hit_count <= '0;
      else if (hit_xfer && hit_count != HIT_MAX)
        hit_count <= hit_count + 1'b1;

      if (accept && cmp_op_illegal(op))
        op_err <= 1'b1;
      else if (count_clr)
        op_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_magma_cmp_stream.sv
// tb/tb_magma_cmp_stream.sv - directed scoreboard bench for magma_cmp_stream
// Expected values follow MAGMA_CMP_SIGNED_EN the same way the build does.
module tb_magma_cmp_stream;

  localparam int W    = 8;
  localparam int CW   = 3;
  localparam int HMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [W-1:0]  i0, i1;
  logic [2:0]    op;
  logic          in_valid, in_ready;
  logic          o, out_valid, out_ready;
  logic          count_clr;
  logic [CW-1:0] hit_count;
  logic          op_err;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  int hit_m  = 0;
  bit err_m  = 0;

  always #5 clk = ~clk;

  magma_cmp_stream #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .CLK      (clk),
    .RESETN   (resetn),
    .I0       (i0),
    .I1       (i1),
    .op       (op),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .O        (o),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count_clr(count_clr),
    .hit_count(hit_count),
    .op_err   (op_err)
  );

  function automatic bit ref_illegal(input logic [2:0] c);
`ifdef MAGMA_CMP_SIGNED_EN
    return 1'b0;
`else
    return c >= 3'd6;
`endif
  endfunction

  function automatic bit ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    case (c)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return a < b;
      3'd3: return a <= b;
      3'd4: return a > b;
      3'd5: return a >= b;
`ifdef MAGMA_CMP_SIGNED_EN
      3'd6: return $signed(a) < $signed(b);
      default: return $signed(a) >= $signed(b);
`else
      default: return 1'b0;
`endif
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    i0 = a; i1 = b; op = c; in_valid = 1'b1;
  endtask

  // One clock: score handshakes at negedge, then check counter/flag after the edge.
  task automatic cyc();
    bit acc, del, e;
    @(negedge clk);
    e = 1'b0;
    if (resetn) begin
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        chk("unexpected_output", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result", 32'(o), 32'(e));
        end
      end
      if (acc) exp_q.push_back(ref_cmp(i0, i1, op));
      if (count_clr) hit_m = 0;
      else if (del && e && hit_m < HMAX) hit_m++;
      if (acc && ref_illegal(op)) err_m = 1'b1;
      else if (count_clr) err_m = 1'b0;
    end else begin
      exp_q.delete();
      hit_m = 0;
      err_m = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("hit_count", 32'(hit_count), 32'(hit_m));
    chk("op_err", 32'(op_err), 32'(err_m));
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; count_clr = 1'b0;
    i0 = '0; i1 = '0; op = '0;
    cyc(); cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1;

    // Full-rate stream, two-cycle latency
    out_ready = 1'b1;
    drive(8'd5, 8'd5, 3'd0);     cyc();
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    drive(8'd3, 8'd9, 3'd2);     cyc();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_o", 32'(o), 32'd1);
    drive(8'd9, 8'd3, 3'd5);     cyc();
    drive(8'd200, 8'd100, 3'd4); cyc();
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("hit_four", 32'(hit_count), 32'd4);

    // Backpressure: two beats fill the pipe, third stalls
    out_ready = 1'b0;
    drive(8'd9, 8'd3, 3'd2);
    chk("bp_rdy0", 32'(in_ready), 32'd1);
    cyc();
    drive(8'd1, 8'd2, 3'd3);
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    cyc();
    drive(8'd7, 8'd7, 3'd1);
    chk("bp_full", 32'(in_ready), 32'd0);
    cyc(); cyc();
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_o", 32'(o), 32'd0);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_idle", 32'(out_valid), 32'd0);

    // Signed opcodes
    drive(8'hFF, 8'h01, 3'd6); cyc();
    chk("slt_err", 32'(op_err), 32'(ref_illegal(3'd6)));
    drive(8'h80, 8'h7F, 3'd7); cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    count_clr = 1'b1; cyc(); count_clr = 1'b0;
    chk("err_cleared", 32'(op_err), 32'd0);
    drive(8'h00, 8'h01, 3'd6);
    count_clr = 1'b1; cyc(); count_clr = 1'b0;
    in_valid = 1'b0;
    chk("err_set_wins", 32'(op_err), 32'(ref_illegal(3'd6)));
    cyc(); cyc();

    // Saturation at 2^CW-1
    for (int k = 0; k < 9; k++) begin
      drive(W'(k), W'(k), 3'd0);
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();
    chk("hit_sat", 32'(hit_count), 32'(HMAX));

    // Clear coincident with a true transfer
    drive(8'd1, 8'd1, 3'd5); cyc();
    in_valid = 1'b0; cyc();
    chk("clr_pending", 32'(out_valid && o), 32'd1);
    count_clr = 1'b1; cyc(); count_clr = 1'b0;
    chk("clr_wins", 32'(hit_count), 32'd0);
    cyc();

    // Reset with both stages full; inputs during reset ignored
    out_ready = 1'b0;
    drive(8'd4, 8'd4, 3'd0); cyc();
    drive(8'd6, 8'd2, 3'd4); cyc();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    drive(8'd8, 8'd8, 3'd0);
    resetn = 1'b0; out_ready = 1'b1; cyc();
    resetn = 1'b1; in_valid = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("no_stale", 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
